// File: rtl/ddfs_pkg.sv
// Shared definitions for the DDFS sweep controller slice.
// State encoding and default field widths.
package ddfs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_FCW_WIDTH = 32;
    localparam int DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/ddfs_dwell_timer.sv
// Loadable down-counter timing the dwell of each tone.
// Load wins over decrement; the counter parks at zero.
module ddfs_dwell_timer
    import ddfs_pkg::*;
#(
    parameter int W = DEF_CNT_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;
    localparam logic [W-1:0] ONE = 1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ddfs_sweep_controller.sv
// Stepped-frequency sweep sequencer driving a DDFS tone word.
// LOAD counts as the first dwell cycle of the start tone.
module ddfs_sweep_controller
    import ddfs_pkg::*;
#(
    parameter int FCW_WIDTH = DEF_FCW_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [FCW_WIDTH-1:0] i_start_fcw,
    input  logic [FCW_WIDTH-1:0] i_step_fcw,
    input  logic [CNT_WIDTH-1:0] i_num_steps,
    input  logic [CNT_WIDTH-1:0] i_dwell,
    input  logic                 i_repeat,
    input  logic                 i_abort,
    output logic [FCW_WIDTH-1:0] o_freq_control,
    output logic                 o_ddfs_rst,
    output logic                 o_busy,
    output logic                 o_step_strobe,
    output logic [CNT_WIDTH-1:0] o_step_index,
    output logic                 o_done
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t               state;
    logic [FCW_WIDTH-1:0] start_q;
    logic [FCW_WIDTH-1:0] step_q;
    logic [CNT_WIDTH-1:0] steps_q;
    logic [CNT_WIDTH-1:0] dwell_m1_q;
    logic                 repeat_q;

    logic [CNT_WIDTH-1:0] dwell_m1_in;
    logic                 in_tone;
    logic                 tone_end;
    logic                 last_tone;
    logic                 tmr_load;
    logic [CNT_WIDTH-1:0] tmr_value;
    logic                 tmr_zero;

    assign o_cfg_ready = (state == IDLE);
    assign dwell_m1_in = (i_dwell == '0) ? '0 : i_dwell - CNT_ONE;
    assign in_tone     = (state == LOAD) || (state == DWELL);
    assign tone_end    = in_tone && tmr_zero;
    assign last_tone   = (o_step_index == steps_q);

    // Reload on accept, at every tone boundary, and clear on abort.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = dwell_m1_q;
        if (state == IDLE) begin
            tmr_load  = i_cfg_valid;
            tmr_value = dwell_m1_in;
        end else if (i_abort) begin
            tmr_load  = 1'b1;
            tmr_value = '0;
        end else if (tone_end) begin
            tmr_load  = 1'b1;
        end
    end

    ddfs_dwell_timer #(.W(CNT_WIDTH)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .en      (in_tone),
        .zero    (tmr_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            start_q        <= '0;
            step_q         <= '0;
            steps_q        <= '0;
            dwell_m1_q     <= '0;
            repeat_q       <= 1'b0;
            o_freq_control <= '0;
            o_ddfs_rst     <= 1'b0;
            o_busy         <= 1'b0;
            o_step_strobe  <= 1'b0;
            o_step_index   <= '0;
            o_done         <= 1'b0;
        end else begin
            o_ddfs_rst    <= 1'b0;
            o_step_strobe <= 1'b0;
            o_done        <= 1'b0;
            if (state != IDLE && i_abort) begin
                state          <= IDLE;
                o_freq_control <= '0;
                o_step_index   <= '0;
                o_busy         <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (i_cfg_valid) begin
                            start_q        <= i_start_fcw;
                            step_q         <= i_step_fcw;
                            steps_q        <= i_num_steps;
                            dwell_m1_q     <= dwell_m1_in;
                            repeat_q       <= i_repeat;
                            o_freq_control <= i_start_fcw;
                            o_ddfs_rst     <= 1'b1;
                            o_step_index   <= '0;
                            o_busy         <= 1'b1;
                            state          <= LOAD;
                        end
                    end
                    LOAD, DWELL: begin
                        if (!tmr_zero) begin
                            state <= DWELL;
                        end else if (!last_tone) begin
                            o_freq_control <= o_freq_control + step_q;
                            o_step_index   <= o_step_index + CNT_ONE;
                            o_step_strobe  <= 1'b1;
                            state          <= DWELL;
                        end else if (repeat_q) begin
                            o_freq_control <= start_q;
                            o_ddfs_rst     <= 1'b1;
                            o_step_index   <= '0;
                            state          <= LOAD;
                        end else begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddfs_sweep_controller.sv
// Scoreboard bench for ddfs_sweep_controller: per-busy-cycle
// expected records are queued by stimulus and popped by a monitor.
module tb_ddfs_sweep_controller;

    typedef struct packed {
        logic [31:0] fcw;
        logic [15:0] idx;
        logic        stb;
        logic        drst;
        logic        done;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] start_fcw;
    logic [31:0] step_fcw;
    logic [15:0] num_steps;
    logic [15:0] dwell;
    logic        rep;
    logic        abort;
    logic [31:0] freq_control;
    logic        ddfs_rst;
    logic        busy;
    logic        step_strobe;
    logic [15:0] step_index;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    rec_t        exp_q[$];
    logic [31:0] tones[$];
    rec_t        mon_e;
    rec_t        mon_got;

    ddfs_sweep_controller dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cfg_valid    (cfg_valid),
        .o_cfg_ready    (cfg_ready),
        .i_start_fcw    (start_fcw),
        .i_step_fcw     (step_fcw),
        .i_num_steps    (num_steps),
        .i_dwell        (dwell),
        .i_repeat       (rep),
        .i_abort        (abort),
        .o_freq_control (freq_control),
        .o_ddfs_rst     (ddfs_rst),
        .o_busy         (busy),
        .o_step_strobe  (step_strobe),
        .o_step_index   (step_index),
        .o_done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && busy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_busy t=%0t got fcw=%h idx=%0d want no busy cycle",
                         $time, freq_control, step_index);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_got = '{freq_control, step_index, step_strobe, ddfs_rst, done};
                if (mon_got !== mon_e) begin
                    errors++;
                    $display("FAIL trace t=%0t got fcw=%h idx=%0d stb=%b rst=%b done=%b want fcw=%h idx=%0d stb=%b rst=%b done=%b",
                             $time, mon_got.fcw, mon_got.idx, mon_got.stb, mon_got.drst, mon_got.done,
                             mon_e.fcw, mon_e.idx, mon_e.stb, mon_e.drst, mon_e.done);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // One pass over the hand-listed tones, d cycles each.
    task automatic push_pass(input int d);
        rec_t r;
        for (int k = 0; k < tones.size(); k++) begin
            for (int c = 0; c < d; c++) begin
                r.fcw  = tones[k];
                r.idx  = 16'(k);
                r.stb  = (k > 0 && c == 0);
                r.drst = (k == 0 && c == 0);
                r.done = 1'b0;
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic push_done();
        rec_t r;
        r.fcw  = tones[tones.size()-1];
        r.idx  = 16'(tones.size() - 1);
        r.stb  = 1'b0;
        r.drst = 1'b0;
        r.done = 1'b1;
        exp_q.push_back(r);
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] st,
                        input logic [15:0] n, input logic [15:0] d,
                        input logic rp, input logic ab);
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        start_fcw = s;
        step_fcw  = st;
        num_steps = n;
        dwell     = d;
        rep       = rp;
        abort     = ab;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && cfg_ready) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending records want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        start_fcw = '0;
        step_fcw  = '0;
        num_steps = '0;
        dwell     = '0;
        rep       = 1'b0;
        abort     = 1'b0;
        #22;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_fcw", freq_control, 32'h0);
        chk("rst_outs", {27'd0, busy, step_strobe, ddfs_rst, done, cfg_ready}, 32'h1);
        chk("rst_idx", {16'd0, step_index}, 32'h0);

        // Basic sweep: 4 tones, dwell 4, done in busy cycle 17
        tones = '{32'h0100_0000, 32'h0110_0000, 32'h0120_0000, 32'h0130_0000};
        push_pass(4);
        push_done();
        send(32'h0100_0000, 32'h0010_0000, 16'd3, 16'd4, 1'b0, 1'b0);
        wait_idle("basic");

        // Dwell 0, single tone; abort alongside valid in IDLE still accepts
        tones = '{32'h1234_5678};
        push_pass(1);
        push_done();
        send(32'h1234_5678, 32'h0000_0001, 16'd0, 16'd0, 1'b0, 1'b1);
        wait_idle("edge");

        // Wrap mod 2^32; descriptor writes while busy are ignored
        tones = '{32'hFFFF_FF00, 32'h0000_0100};
        push_pass(2);
        push_done();
        send(32'hFFFF_FF00, 32'h0000_0200, 16'd1, 16'd2, 1'b0, 1'b0);
        cfg_valid = 1'b1;
        start_fcw = 32'hDEAD_BEEF;
        num_steps = 16'd7;
        @(posedge clk);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        wait_idle("wrap");

        // Negative step
        tones = '{32'h0100_0000, 32'h00F0_0000, 32'h00E0_0000};
        push_pass(1);
        push_done();
        send(32'h0100_0000, 32'hFFF0_0000, 16'd2, 16'd1, 1'b0, 1'b0);
        wait_idle("neg");

        // Repeat: three passes plus the next LOAD, then abort
        tones = '{32'h0040_0000, 32'h0041_0000};
        push_pass(2);
        push_pass(2);
        push_pass(2);
        exp_q.push_back('{32'h0040_0000, 16'd0, 1'b0, 1'b1, 1'b0});
        send(32'h0040_0000, 32'h0001_0000, 16'd1, 16'd2, 1'b1, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_fcw", freq_control, 32'h0);
        chk("abort_idle", {30'd0, busy, cfg_ready}, 32'h1);
        chk("abort_pending", exp_q.size(), 32'h0);
        wait_idle("repeat");

        // Async reset mid-dwell of tone 1
        tones = '{32'h0100_0000, 32'h0110_0000, 32'h0120_0000, 32'h0130_0000};
        push_pass(4);
        repeat (10) void'(exp_q.pop_back());
        send(32'h0100_0000, 32'h0010_0000, 16'd3, 16'd4, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fcw", freq_control, 32'h0);
        chk("arst_outs", {27'd0, busy, step_strobe, ddfs_rst, done, cfg_ready}, 32'h1);
        chk("arst_idx", {16'd0, step_index}, 32'h0);
        chk("arst_pending", exp_q.size(), 32'h0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("arst_ready", {31'd0, cfg_ready}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
